// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state and host command encodings.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RESET = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_STEP  = 3'd4,
      ST_FAULT = 3'd5
   } ctrl_state_t;

   typedef enum logic [1:0] {
      CMD_LOAD = 2'd0,
      CMD_RUN  = 2'd1,
      CMD_STEP = 2'd2,
      CMD_HALT = 2'd3
   } host_cmd_t;

endpackage

// File: rtl/cpu_run_controller_if.sv
// Host link: command channel plus program-word stream, both valid/ready.
interface cpu_run_controller_if #(
   parameter int unsigned ADDR_WIDTH = 16
);
   logic                  host_cmd_valid;
   logic                  host_cmd_ready;
   logic [1:0]            host_cmd;
   logic [ADDR_WIDTH-2:0] load_count;
   logic                  prog_valid;
   logic                  prog_ready;
   logic [31:0]           prog_data;

   modport master (
      output host_cmd_valid, host_cmd, load_count, prog_valid, prog_data,
      input  host_cmd_ready, prog_ready
   );

   modport slave (
      input  host_cmd_valid, host_cmd, load_count, prog_valid, prog_data,
      output host_cmd_ready, prog_ready
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cpu_run_controller.sv
// Host-side sequencer: program load, pipeline reset, run/step/halt gating and sticky fault.
module cpu_run_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 16,
   parameter int unsigned CYCLE_CNT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   cpu_run_controller_if.slave        host,
   output logic                       cpu_rst,
   output logic                       debug_enable,
   output logic                       instruction_write,
   output logic [31:0]                instruction_in,
   input  logic                       data_access_fault_exception,
   output logic [2:0]                 ctrl_state,
   output logic                       fault,
   output logic [CYCLE_CNT_WIDTH-1:0] cycle_count
);

   localparam int unsigned RW = ADDR_WIDTH - 1;
   localparam logic [RW-1:0] CAP = {1'b1, {(ADDR_WIDTH-2){1'b0}}};

   ctrl_state_t   state, state_next;
   host_cmd_t     cmd;
   logic [RW-1:0] remaining, remaining_next, clamped;
   logic          running;
   logic          cmd_fire, word_fire, fault_sample;

   assign cmd       = host_cmd_t'(host.host_cmd);
   assign clamped   = (host.load_count > CAP) ? CAP : host.load_count;
   assign cmd_fire  = host.host_cmd_valid && host.host_cmd_ready;
   assign word_fire = host.prog_valid && host.prog_ready;

   // Faults are only meaningful while the pipeline may be executing or parked.
   assign fault_sample = data_access_fault_exception &&
                         ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_STEP));

   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      case (state)
         ST_IDLE: begin
            if (cmd_fire) begin
               case (cmd)
                  CMD_LOAD: begin
                     state_next     = ST_RESET;
                     remaining_next = clamped;
                  end
                  CMD_RUN:  state_next = ST_RUN;
                  CMD_STEP: state_next = ST_STEP;
                  default:  state_next = ST_IDLE;
               endcase
            end
         end
         ST_RESET: state_next = (remaining == '0) ? ST_IDLE : ST_LOAD;
         ST_LOAD: begin
            if (word_fire) begin
               remaining_next = remaining - RW'(1);
               if (remaining == RW'(1)) state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cmd_fire && (cmd == CMD_HALT)) state_next = ST_IDLE;
         end
         ST_STEP: state_next = ST_IDLE;
         ST_FAULT: begin
            if (cmd_fire && (cmd == CMD_LOAD)) begin
               state_next     = ST_RESET;
               remaining_next = clamped;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (fault_sample) state_next = ST_FAULT;
   end

   // running keeps cpu_rst high and readies low until the first edge after rst releases.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= ST_IDLE;
         remaining         <= '0;
         running           <= 1'b0;
         instruction_write <= 1'b0;
         instruction_in    <= '0;
      end else begin
         state             <= state_next;
         remaining         <= remaining_next;
         running           <= 1'b1;
         instruction_write <= word_fire;
         if (word_fire) instruction_in <= host.prog_data;
      end
   end

   assign host.host_cmd_ready = running &&
                                ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_FAULT));
   assign host.prog_ready     = (state == ST_LOAD);
   assign debug_enable        = (state == ST_RUN) || (state == ST_STEP);
   assign cpu_rst             = !running || (state == ST_RESET);
   assign fault               = (state == ST_FAULT);
   assign ctrl_state          = state;

   sat_counter #(
      .WIDTH (CYCLE_CNT_WIDTH)
   ) u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (state == ST_RESET),
      .en    (debug_enable),
      .count (cycle_count)
   );

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: load, run/step/halt, fault, saturation, clamp, reset.
module tb_cpu_run_controller;
   import cpu_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Main instance: default widths
   cpu_run_controller_if #(.ADDR_WIDTH(16)) hif ();
   logic        cpu_rst, dbg, iw, flt, fexc;
   logic [31:0] ii, cc;
   logic [2:0]  st;

   cpu_run_controller #(.ADDR_WIDTH(16), .CYCLE_CNT_WIDTH(32)) dut (
      .clk                         (clk),
      .rst                         (rst),
      .host                        (hif),
      .cpu_rst                     (cpu_rst),
      .debug_enable                (dbg),
      .instruction_write           (iw),
      .instruction_in              (ii),
      .data_access_fault_exception (fexc),
      .ctrl_state                  (st),
      .fault                       (flt),
      .cycle_count                 (cc)
   );

   // Small instance: CAP=4 words, 4-bit cycle counter
   cpu_run_controller_if #(.ADDR_WIDTH(4)) sif ();
   logic        s_cpu_rst, s_dbg, s_iw, s_flt, s_fexc;
   logic [31:0] s_ii;
   logic [3:0]  s_cc;
   logic [2:0]  s_st;

   cpu_run_controller #(.ADDR_WIDTH(4), .CYCLE_CNT_WIDTH(4)) dut_s (
      .clk                         (clk),
      .rst                         (rst),
      .host                        (sif),
      .cpu_rst                     (s_cpu_rst),
      .debug_enable                (s_dbg),
      .instruction_write           (s_iw),
      .instruction_in              (s_ii),
      .data_access_fault_exception (s_fexc),
      .ctrl_state                  (s_st),
      .fault                       (s_flt),
      .cycle_count                 (s_cc)
   );

   logic [31:0] prog_w [3];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s observed=timeout expected=handshake", tag);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers a command and returns 1 time unit after the edge that accepted it.
   task automatic send_cmd(input logic [1:0] c, input logic [14:0] n);
      bit done;
      done = 1'b0;
      hif.host_cmd       = c;
      hif.load_count     = n;
      hif.host_cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (hif.host_cmd_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      hif.host_cmd_valid = 1'b0;
      if (!done) timeout("cmd_handshake");
   endtask

   task automatic load_words(input int unsigned n);
      bit done;
      for (int unsigned w = 0; w < n; w++) begin
         hif.prog_data  = prog_w[w];
         hif.prog_valid = 1'b1;
         done = 1'b0;
         for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (hif.prog_ready) begin
               @(posedge clk);
               #1;
               done = 1'b1;
            end
         end
         if (!done) timeout("prog_handshake");
         chk("load_iw", {63'd0, iw}, 64'd1);
         chk("load_ii", {32'd0, ii}, {32'd0, prog_w[w]});
      end
      hif.prog_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      prog_w[0] = 32'h0050_0093;
      prog_w[1] = 32'h0010_8113;
      prog_w[2] = 32'h0000_006F;
      hif.host_cmd_valid = 1'b0; hif.host_cmd = 2'd0; hif.load_count = '0;
      hif.prog_valid = 1'b0; hif.prog_data = '0;
      sif.host_cmd_valid = 1'b0; sif.host_cmd = 2'd0; sif.load_count = '0;
      sif.prog_valid = 1'b0; sif.prog_data = '0;
      fexc = 1'b0; s_fexc = 1'b0;

      // Reset values
      #3;
      chk("rst_state", {61'd0, st}, 64'd0);
      chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
      chk("rst_dbg", {63'd0, dbg}, 64'd0);
      chk("rst_iw", {63'd0, iw}, 64'd0);
      chk("rst_ii", {32'd0, ii}, 64'd0);
      chk("rst_fault", {63'd0, flt}, 64'd0);
      chk("rst_cc", {32'd0, cc}, 64'd0);
      chk("rst_hcr", {63'd0, hif.host_cmd_ready}, 64'd0);
      chk("rst_pr", {63'd0, hif.prog_ready}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("rel_cpu_rst", {63'd0, cpu_rst}, 64'd0);
      chk("rel_hcr", {63'd0, hif.host_cmd_ready}, 64'd1);

      // HALT in IDLE is a no-op
      send_cmd(CMD_HALT, 15'd0);
      chk("idle_halt_state", {61'd0, st}, 64'd0);

      // LOAD 3 words back-to-back
      send_cmd(CMD_LOAD, 15'd3);
      chk("load_reset_state", {61'd0, st}, 64'd1);
      chk("load_reset_cpu_rst", {63'd0, cpu_rst}, 64'd1);
      chk("load_reset_hcr", {63'd0, hif.host_cmd_ready}, 64'd0);
      tick();
      chk("load_state", {61'd0, st}, 64'd2);
      chk("load_pr", {63'd0, hif.prog_ready}, 64'd1);
      chk("load_cpu_rst", {63'd0, cpu_rst}, 64'd0);
      load_words(3);
      chk("load_done_state", {61'd0, st}, 64'd0);
      chk("load_done_pr", {63'd0, hif.prog_ready}, 64'd0);
      tick();
      chk("load_done_iw", {63'd0, iw}, 64'd0);

      // LOAD of zero words
      send_cmd(CMD_LOAD, 15'd0);
      chk("load0_state", {61'd0, st}, 64'd1);
      chk("load0_cpu_rst", {63'd0, cpu_rst}, 64'd1);
      tick();
      chk("load0_idle", {61'd0, st}, 64'd0);
      chk("load0_iw", {63'd0, iw}, 64'd0);

      // RUN for 10 cycles then HALT
      send_cmd(CMD_RUN, 15'd0);
      chk("run_dbg_first", {63'd0, dbg}, 64'd1);
      chk("run_cc_start", {32'd0, cc}, 64'd0);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("run_dbg", {63'd0, dbg}, 64'd1);
      end
      send_cmd(CMD_HALT, 15'd0);
      chk("halt_dbg", {63'd0, dbg}, 64'd0);
      chk("halt_cc", {32'd0, cc}, 64'd10);

      // Two single steps
      for (int i = 0; i < 2; i++) begin
         send_cmd(CMD_STEP, 15'd0);
         chk("step_dbg", {63'd0, dbg}, 64'd1);
         chk("step_hcr", {63'd0, hif.host_cmd_ready}, 64'd0);
         tick();
         chk("step_dbg_off", {63'd0, dbg}, 64'd0);
         chk("step_state", {61'd0, st}, 64'd0);
      end
      chk("step_cc", {32'd0, cc}, 64'd12);

      // Fault coincident with an accepted HALT during RUN
      send_cmd(CMD_RUN, 15'd0);
      hif.host_cmd = CMD_HALT; hif.host_cmd_valid = 1'b1; fexc = 1'b1;
      tick();
      hif.host_cmd_valid = 1'b0; fexc = 1'b0;
      chk("fault_state", {61'd0, st}, 64'd5);
      chk("fault_flag", {63'd0, flt}, 64'd1);
      chk("fault_dbg", {63'd0, dbg}, 64'd0);
      chk("fault_cc", {32'd0, cc}, 64'd13);
      send_cmd(CMD_RUN, 15'd0);
      chk("fault_run_state", {61'd0, st}, 64'd5);
      chk("fault_run_dbg", {63'd0, dbg}, 64'd0);
      send_cmd(CMD_STEP, 15'd0);
      chk("fault_step_state", {61'd0, st}, 64'd5);
      send_cmd(CMD_LOAD, 15'd0);
      chk("fault_clr_state", {61'd0, st}, 64'd1);
      chk("fault_clr_flag", {63'd0, flt}, 64'd0);
      tick();
      chk("fault_clr_idle", {61'd0, st}, 64'd0);
      chk("fault_clr_cc", {32'd0, cc}, 64'd0);

      // Reset asserted mid-LOAD after one word
      send_cmd(CMD_LOAD, 15'd3);
      tick();
      hif.prog_data = prog_w[0]; hif.prog_valid = 1'b1;
      tick();
      chk("midrst_w0", {63'd0, iw}, 64'd1);
      rst = 1'b0;
      #1;
      chk("midrst_state", {61'd0, st}, 64'd0);
      chk("midrst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
      chk("midrst_iw", {63'd0, iw}, 64'd0);
      chk("midrst_ii", {32'd0, ii}, 64'd0);
      chk("midrst_pr", {63'd0, hif.prog_ready}, 64'd0);
      chk("midrst_hcr", {63'd0, hif.host_cmd_ready}, 64'd0);
      hif.prog_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("midrst_rel_state", {61'd0, st}, 64'd0);
      send_cmd(CMD_LOAD, 15'd3);
      tick();
      load_words(3);
      chk("reload_state", {61'd0, st}, 64'd0);

      // Saturating 4-bit counter: RUN 20 cycles
      sif.host_cmd = CMD_RUN; sif.host_cmd_valid = 1'b1;
      tick();
      sif.host_cmd_valid = 1'b0;
      chk("sat_run_state", {61'd0, s_st}, 64'd3);
      repeat (20) tick();
      chk("sat_cc", {60'd0, s_cc}, 64'd15);
      sif.host_cmd = CMD_HALT; sif.host_cmd_valid = 1'b1;
      tick();
      sif.host_cmd_valid = 1'b0;
      chk("sat_halt_state", {61'd0, s_st}, 64'd0);
      chk("sat_hold_cc", {60'd0, s_cc}, 64'd15);

      // load_count 6 clamps to CAP=4 words
      sif.host_cmd = CMD_LOAD; sif.load_count = 3'd6; sif.host_cmd_valid = 1'b1;
      sif.prog_valid = 1'b1; sif.prog_data = 32'hA000_0000;
      tick();
      sif.host_cmd_valid = 1'b0;
      chk("clamp_reset", {61'd0, s_st}, 64'd1);
      tick();
      chk("clamp_load", {61'd0, s_st}, 64'd2);
      chk("clamp_cc_clr", {60'd0, s_cc}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         sif.prog_data = 32'hA000_0000 + 32'(i);
         tick();
         chk("clamp_iw", {63'd0, s_iw}, 64'd1);
         chk("clamp_ii", {32'd0, s_ii}, {32'd0, 32'hA000_0000 + 32'(i)});
      end
      chk("clamp_idle", {61'd0, s_st}, 64'd0);
      chk("clamp_pr", {63'd0, sif.prog_ready}, 64'd0);
      tick();
      chk("clamp_no_extra", {63'd0, s_iw}, 64'd0);
      sif.prog_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
